// File: rtl/jtag_debug_cmd_queue_if.sv
// jtag_debug_cmd_queue_if: debug command handshake bus from the queue to the per-core debug targets.
// Ports: cmd_valid (one-hot per channel), cmd_ready (per channel), cmd_ir (head IR), jdo (head DR data).
interface jtag_debug_cmd_queue_if #(
  parameter int IR_W = 2,
  parameter int SR_W = 38,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] cmd_valid;
  logic [NUM_CH-1:0] cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  modport master(output cmd_valid, cmd_ir, jdo, input cmd_ready);
  modport slave(input cmd_valid, cmd_ir, jdo, output cmd_ready);
endinterface

// File: rtl/jtag_debug_cmd_queue.sv
// jtag_debug_cmd_queue: syncs virtual-JTAG update strobes into clk, queues {IR, DR} commands, delivers them per channel.
// Ports: clk, reset (async high), vs_uir/vs_udr strobes, ir_in, sr, ovf_clr, fifo_level, ovf, armed, bus (master).
module jtag_debug_cmd_queue #(
  parameter int SR_W = 38,
  parameter int IR_W = 2,
  parameter int CH_SEL_W = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic vs_uir,
  input  logic vs_udr,
  input  logic [IR_W-1:0] ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic ovf_clr,
  output logic [FIFO_AW:0] fifo_level,
  output logic ovf,
  output logic armed,
  jtag_debug_cmd_queue_if.master bus
);
  localparam int NUM_CH = 2 ** CH_SEL_W;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] uir_s, udr_s;
  logic uir_d, udr_d, uir_p, udr_p;
  logic [CW-1:0] arm_cnt;
  logic [IR_W-1:0] ir_latched;
  logic [FIFO_AW:0] wptr, rptr;
  logic [IR_W+SR_W-1:0] mem [DEPTH];
  logic [IR_W+SR_W-1:0] head;
  logic [CH_SEL_W-1:0] ch_head;
  logic nonempty, full, pop, wr, drop;
  assign armed = arm_cnt == CW'(SYNC_STAGES + 1);
  always_comb begin
    fifo_level = wptr - rptr;
    nonempty = fifo_level != '0;
    full = fifo_level == (FIFO_AW + 1)'(DEPTH);
    head = mem[rptr[FIFO_AW-1:0]];
    ch_head = head[SR_W-1 -: CH_SEL_W];
    bus.cmd_valid = nonempty ? NUM_CH'(1) << ch_head : '0;
    bus.cmd_ir = nonempty ? head[IR_W+SR_W-1:SR_W] : '0;
    bus.jdo = nonempty ? head[SR_W-1:0] : '0;
    pop = |(bus.cmd_valid & bus.cmd_ready);
    wr = udr_p & (~full | pop);
    drop = udr_p & full & ~pop;
  end
  // Edge pulses are registered, giving SYNC_STAGES+1 edges from first sample to push
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      uir_s <= '0;
      udr_s <= '0;
      uir_d <= 1'b0;
      udr_d <= 1'b0;
      uir_p <= 1'b0;
      udr_p <= 1'b0;
      arm_cnt <= '0;
      ir_latched <= '0;
      wptr <= '0;
      rptr <= '0;
      ovf <= 1'b0;
    end else begin
      uir_s <= {uir_s[SYNC_STAGES-2:0], vs_uir};
      udr_s <= {udr_s[SYNC_STAGES-2:0], vs_udr};
      uir_d <= uir_s[SYNC_STAGES-1];
      udr_d <= udr_s[SYNC_STAGES-1];
      uir_p <= armed & uir_s[SYNC_STAGES-1] & ~uir_d;
      udr_p <= armed & udr_s[SYNC_STAGES-1] & ~udr_d;
      arm_cnt <= armed ? arm_cnt : arm_cnt + 1'b1;
      if (uir_p) ir_latched <= ir_in;
      wptr <= wptr + (FIFO_AW + 1)'(wr);
      rptr <= rptr + (FIFO_AW + 1)'(pop);
      ovf <= drop | (ovf & ~ovf_clr);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr[FIFO_AW-1:0]] <= {ir_latched, sr};
endmodule
